// File: rtl/add8_serial_recover_if.sv
// Handshake bundle for add8_serial_recover: operand-pair input channel and result output channel.
interface add8_serial_recover_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH:0]   in_s;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_b;
  logic             out_err;

  modport master (
    output in_valid, in_a, in_s, out_ready,
    input  in_ready, out_valid, out_b, out_err
  );

  modport slave (
    input  in_valid, in_a, in_s, out_ready,
    output in_ready, out_valid, out_b, out_err
  );
endinterface

// File: rtl/add8_serial_recover.sv
// Bit-serial operand recovery B = S - A with ripple borrow, LSB first, one bit per clock.
// Flags sums that no WIDTH-bit B can produce.
module add8_serial_recover #(
  parameter int unsigned WIDTH = 8
) (
  input logic                  clk,
  input logic                  rst,
  add8_serial_recover_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q;
  logic [WIDTH:0]   s_q;
  logic [WIDTH:0]   a_q;
  logic [WIDTH:0]   d_q;
  logic             br_q;
  logic [CW-1:0]    cnt_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_b_q;
  logic             out_err_q;

  logic             bit_d;
  logic             br_d;
  logic [WIDTH:0]   d_d;

  always_comb begin
    bit_d = s_q[0] ^ a_q[0] ^ br_q;
    br_d  = (~s_q[0] & a_q[0]) | (~(s_q[0] ^ a_q[0]) & br_q);
    d_d   = {bit_d, d_q[WIDTH:1]};
  end

  assign bus.in_ready  = (state_q == IDLE) & ~rst;
  assign bus.out_valid = out_valid_q;
  assign bus.out_b     = out_b_q;
  assign bus.out_err   = out_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      s_q         <= '0;
      a_q         <= '0;
      d_q         <= '0;
      br_q        <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_b_q     <= '0;
      out_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            s_q     <= bus.in_s;
            a_q     <= {1'b0, bus.in_a};
            br_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          s_q  <= {1'b0, s_q[WIDTH:1]};
          a_q  <= {1'b0, a_q[WIDTH:1]};
          d_q  <= d_d;
          br_q <= br_d;
          // Terminal count publishes the result straight from the last bit's next-state.
          if (cnt_q == CW'(WIDTH)) begin
            out_b_q     <= d_d[WIDTH-1:0];
            out_err_q   <= d_d[WIDTH] | br_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/add8_serial_recover.md
Name: add8_serial_recover

Overview:
- Inverse-direction companion to the 8-bit ripple-carry adder cells.
- Takes a 9-bit sum S and one operand A, and recovers the other operand B = S - A.
- Works bit-serially with a ripple borrow, LSB first, one bit per clock.
- Used on the consumer side of adder datapaths and in self-check harnesses. It also flags sums that no 8-bit B can produce.

Parameters:
- WIDTH, 8, operand width; the sum is WIDTH+1 bits and a serial pass takes WIDTH+1 bit-cycles.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  source has an operand pair.
- in_ready  output  1  block can accept; high only in IDLE.
- in_a  input  WIDTH  known operand A.
- in_s  input  WIDTH+1  sum S (carry-out in MSB).
- out_valid  output  1  result available.
- out_ready  input  1  sink accepts result.
- out_b  output  WIDTH  recovered operand B.
- out_err  output  1  S - A is outside 0..2^WIDTH-1.

Behaviour:
- Clock and reset (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, out_valid=0, out_b=0, out_err=0, borrow=0, bit counter=0, shift registers=0.
- in_ready is 0 while rst is high. It is 1 in IDLE after reset.
- States:
  - IDLE: in_ready=1. On an edge with in_valid&in_ready:
    - load A zero-extended to WIDTH+1 bits, and S, into shift registers;
    - clear borrow and counter;
    - go to SHIFT.
  - SHIFT: in_ready=0; one bit i per edge, i=0..WIDTH.
    - d_i = s_i ^ a_i ^ br.
    - br' = (~s_i & a_i) | (~(s_i ^ a_i) & br).
    - d_i shifts into the result register from the MSB side; S and A shift right.
    - After the edge processing i=WIDTH, go to DONE.
  - DONE: registered outputs valid.
    - out_b = d[WIDTH-1:0].
    - out_err = d[WIDTH] | final br.
    - out_valid=1.
    - On an edge with out_ready=1: clear out_valid and go to IDLE.
- Latency: out_valid rises WIDTH+1 edges after the accept edge (9 for WIDTH=8).
- Throughput: one transaction per WIDTH+3 cycles minimum (accept, WIDTH+1 shifts, DONE handshake). There is no overlap.
- Backpressure: in DONE with out_ready=0, out_b, out_err and out_valid hold stable indefinitely.
  - in_ready stays 0; in_valid is ignored, and in_a/in_s may change freely.
- Inputs are sampled only on the accept edge; later changes have no effect.
- Error case: out_b still carries the low WIDTH bits of the two's-complement difference (defined, not X).
- Reset mid-operation (SHIFT or DONE) aborts the transaction:
  - the result is discarded and never presented;
  - on the next cycle out_valid=0 and in_ready=1.
- Reset has priority over any handshake on the same edge.
- Counter width is ceil(log2(WIDTH+2)). The counter never wraps: its terminal value forces the transition to DONE.

Test Plan:
1. A=0x5A, S=0x0FF, out_ready=1 -> out_valid exactly 9 edges after accept, out_b=0xA5, out_err=0, IDLE next cycle.
2. A=0xFF, S=0x1FE -> out_b=0xFF, out_err=0 (max carry case). A=0x00, S=0x000 -> out_b=0x00, out_err=0.
3. A=0x01, S=0x000 -> out_err=1 (final borrow), out_b=0xFF. A=0x00, S=0x100 -> out_err=1 (d[8] set), out_b=0x00.
4. Backpressure: case 1 with out_ready=0 for 5 cycles; toggle in_valid and in_a/in_s meanwhile -> outputs constant, in_ready=0, no second accept; release -> IDLE, in_ready=1.
5. Assert rst for 1 cycle during SHIFT at bit 4 of A=0x12, S=0x034 -> out_valid never rises for that transaction, in_ready=1 after reset. A new transaction A=0x12, S=0x034 -> out_b=0x22, out_err=0.
6. Back-to-back: in_valid held high with 3 distinct pairs and out_ready=1 -> 3 correct results, accepts spaced exactly 11 cycles apart, in_ready low between accepts.
